// File: rtl/ram_ctrl_pkg.sv
// Shared types and default widths for the burst RAM controller.
// Holds the controller FSM state enum and width defaults.
package ram_ctrl_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    CLEAR
  } state_e;

endpackage

// File: rtl/ram_rd_stage.sv
// Read output register: holds one beat until the consumer takes it.
// Ports: clk_i/rst_ni, load_req_i, data_i in; load_o, rd_valid_o/rd_data_o out.
module ram_rd_stage
  import ram_ctrl_pkg::*;
#(
  parameter int DW = DEF_DATA_W
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_req_i,
  input  logic [DW-1:0] data_i,
  input  logic          rd_ready_i,
  output logic          load_o,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // Slot is free when empty or being drained this cycle.
  assign load_o = load_req_i && (!valid_q || rd_ready_i);

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_o) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (rd_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rd_valid_o = valid_q;
  assign rd_data_o  = data_q;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write controller for a single-port async-read RAM.
// Ports: Cmd* command channel, Wr* write data, Rd* read data, Ram* RAM side,
// Busy status. Macro RAM_BURST_CTRL_CLEAR_EN zero-fills the RAM after reset.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_W,
  parameter int ADDRESS_WIDTH = DEF_ADDR_W,
  parameter int LEN_WIDTH     = DEF_LEN_W
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     CmdValid,
  output logic                     CmdReady,
  input  logic                     CmdWrite,
  input  logic [ADDRESS_WIDTH-1:0] CmdAddr,
  input  logic [LEN_WIDTH-1:0]     CmdLen,
  input  logic                     WrValid,
  output logic                     WrReady,
  input  logic [DATA_WIDTH-1:0]    WrData,
  output logic                     RdValid,
  input  logic                     RdReady,
  output logic [DATA_WIDTH-1:0]    RdData,
  output logic                     Busy,
  output logic                     RamWrEn,
  output logic [ADDRESS_WIDTH-1:0] RamAddr,
  output logic [DATA_WIDTH-1:0]    RamDataIn,
  input  logic [DATA_WIDTH-1:0]    RamDataOut
);

`ifdef RAM_BURST_CTRL_CLEAR_EN
  localparam state_e RST_STATE = CLEAR;
`else
  localparam state_e RST_STATE = IDLE;
`endif

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]     beats_q, beats_d;
  logic                     rd_load;

  ram_rd_stage #(
    .DW(DATA_WIDTH)
  ) u_rd (
    .clk_i     (Clk),
    .rst_ni    (Rst_n),
    .load_req_i(state_q == READ),
    .data_i    (RamDataOut),
    .rd_ready_i(RdReady),
    .load_o    (rd_load),
    .rd_valid_o(RdValid),
    .rd_data_o (RdData)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    beats_d   = beats_q;
    CmdReady  = 1'b0;
    WrReady   = 1'b0;
    RamWrEn   = 1'b0;
    RamDataIn = '0;
    unique case (state_q)
      IDLE: begin
        CmdReady = 1'b1;
        if (CmdValid) begin
          addr_d  = CmdAddr;
          beats_d = CmdLen;
          state_d = CmdWrite ? WRITE : READ;
        end
      end
      WRITE: begin
        WrReady   = 1'b1;
        RamWrEn   = WrValid;
        RamDataIn = WrData;
        if (WrValid) begin
          addr_d  = addr_q + 1'b1;
          beats_d = beats_q - 1'b1;
          if (beats_q == '0) state_d = IDLE;
        end
      end
      READ: begin
        if (rd_load) begin
          addr_d  = addr_q + 1'b1;
          beats_d = beats_q - 1'b1;
          if (beats_q == '0) state_d = IDLE;
        end
      end
`ifdef RAM_BURST_CTRL_CLEAR_EN
      CLEAR: begin
        RamWrEn = 1'b1;
        addr_d  = addr_q + 1'b1;
        // Last address written; counter wraps back to 0.
        if (&addr_q) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
    end
  end

  assign Busy    = (state_q != IDLE);
  assign RamAddr = addr_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl with a behavioural RAM model.
// Honours RAM_BURST_CTRL_CLEAR_EN when the design is built with it.
module tb_ram_burst_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int LW    = 8;
  localparam int DEPTH = 1 << AW;

`ifdef RAM_BURST_CTRL_CLEAR_EN
  localparam bit RST_BUSY = 1'b1;
`else
  localparam bit RST_BUSY = 1'b0;
`endif

  logic          Clk, Rst_n;
  logic          CmdValid, CmdReady, CmdWrite;
  logic [AW-1:0] CmdAddr;
  logic [LW-1:0] CmdLen;
  logic          WrValid, WrReady;
  logic [DW-1:0] WrData;
  logic          RdValid, RdReady;
  logic [DW-1:0] RdData;
  logic          Busy, RamWrEn;
  logic [AW-1:0] RamAddr;
  logic [DW-1:0] RamDataIn, RamDataOut;

  ram_burst_ctrl #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdWrite(CmdWrite), .CmdAddr(CmdAddr), .CmdLen(CmdLen),
    .WrValid(WrValid), .WrReady(WrReady), .WrData(WrData),
    .RdValid(RdValid), .RdReady(RdReady), .RdData(RdData),
    .Busy(Busy), .RamWrEn(RamWrEn), .RamAddr(RamAddr),
    .RamDataIn(RamDataIn), .RamDataOut(RamDataOut)
  );

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q   [$];
  int checks, errors, rd_mode;
  bit wr_phase;

  assign RamDataOut = mem[RamAddr];
  always @(posedge Clk) if (RamWrEn) mem[RamAddr] <= RamDataIn;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // RdReady pattern generator
  initial begin
    int pat;
    pat = 0;
    forever begin
      @(negedge Clk);
      case (rd_mode)
        0: RdReady = 1'b1;
        1: begin RdReady = (pat % 3 == 0); pat++; end
        2: RdReady = 1'($urandom_range(0, 1));
        default: RdReady = 1'b0;
      endcase
    end
  end

  // Read-channel scoreboard and stray-write watch
  initial begin
    bit pv, pr;
    logic [DW-1:0] pd, ev;
    pv = 0; pr = 0; pd = '0;
    forever begin
      @(negedge Clk); #2;
      if (!Rst_n) pv = 0;
      else begin
        if (pv && !pr) begin
          checks++;
          if (RdValid !== 1'b1 || RdData !== pd) begin
            errors++;
            $display("FAIL rd_hold: RdValid=%b RdData=%h required 1/%h",
                     RdValid, RdData, pd);
          end
        end
        if (RdValid && RdReady) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_extra: beat %h delivered, none expected", RdData);
          end else begin
            ev = exp_q.pop_front();
            if (RdData !== ev) begin
              errors++;
              $display("FAIL rd_data: got %h required %h", RdData, ev);
            end
          end
        end
        if (!wr_phase) begin
          checks++;
          if (RamWrEn !== 1'b0) begin
            errors++;
            $display("FAIL stray_write: RamWrEn=%b required 0 at addr %h",
                     RamWrEn, RamAddr);
          end
        end
        pv = RdValid; pr = RdReady; pd = RdData;
      end
    end
  end

  task automatic send_cmd(input bit wr, input logic [AW-1:0] a,
                          input logic [LW-1:0] len);
    int n;
    @(negedge Clk);
    CmdValid = 1'b1; CmdWrite = wr; CmdAddr = a; CmdLen = len;
    n = 0;
    #1;
    while (!CmdReady && n < 2000) begin
      @(negedge Clk); #1; n++;
    end
    checks++;
    if (CmdReady !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: CmdReady=%b required 1", CmdReady);
    end
    @(posedge Clk); #1;
    CmdValid = 1'b0;
    if (!wr)
      for (int i = 0; i <= int'(len); i++)
        exp_q.push_back(ref_mem[(int'(a) + i) % DEPTH]);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input int len,
                             input bit stall, input int abort_after,
                             input int dbase);
    int i, cyc, ea;
    logic [DW-1:0] d;
    wr_phase = 1;
    send_cmd(1'b1, a, LW'(len));
    i = 0; cyc = 0;
    while (i <= len && cyc < 4000) begin
      @(negedge Clk); cyc++;
      if (abort_after > 0 && i == abort_after) break;
      WrValid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      d = (dbase >= 0) ? DW'(dbase + i) : DW'($urandom);
      WrData = d;
      ea = (int'(a) + i) % DEPTH;
      #1;
      checks++;
      if (WrReady !== 1'b1 || RamWrEn !== WrValid ||
          RamAddr !== AW'(ea) || (WrValid && RamDataIn !== d)) begin
        errors++;
        $display("FAIL wr_beat: rdy=%b we=%b addr=%h din=%h required 1/%b/%h/%h",
                 WrReady, RamWrEn, RamAddr, RamDataIn, WrValid, AW'(ea), d);
      end
      if (WrValid) begin
        ref_mem[ea] = d;
        i++;
      end
    end
    if (abort_after == 0) begin
      @(negedge Clk);
      WrValid = 1'b0;
      #1;
      checks++;
      if (Busy !== 1'b0 || CmdReady !== 1'b1) begin
        errors++;
        $display("FAIL wr_done: Busy=%b CmdReady=%b required 0/1",
                 Busy, CmdReady);
      end
      wr_phase = 0;
    end
  endtask

  task automatic drain(input int mode);
    int n;
    rd_mode = mode;
    n = 0;
    @(negedge Clk); #3;
    while ((exp_q.size() != 0 || Busy || RdValid) && n < 3000) begin
      @(negedge Clk); #3; n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

`ifdef RAM_BURST_CTRL_CLEAR_EN
  task automatic wait_clear();
    int n;
    wr_phase = 1;
    n = 0;
    #1;
    while (Busy && n < 1100) begin
      n++;
      if (CmdReady !== 1'b0) begin
        errors++;
        $display("FAIL clear_ready: CmdReady=%b required 0", CmdReady);
      end
      @(negedge Clk); #1;
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clear_len: busy %0d cycles required %0d", n, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    wr_phase = 0;
  endtask
`endif

  task automatic test_reset();
    #12;
    checks++;
    if (RamAddr !== '0 || RamWrEn !== 1'b0 || RamDataIn !== '0 ||
        RdValid !== 1'b0 || RdData !== '0 || Busy !== RST_BUSY ||
        CmdReady !== !RST_BUSY || WrReady !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: addr=%h we=%b din=%h rv=%b rd=%h busy=%b cr=%b wr=%b",
               RamAddr, RamWrEn, RamDataIn, RdValid, RdData, Busy,
               CmdReady, WrReady);
    end
    @(negedge Clk);
    Rst_n = 1'b1;
`ifdef RAM_BURST_CTRL_CLEAR_EN
    wait_clear();
    rd_mode = 0;
    send_cmd(1'b0, 10'h3FF, 8'd0);
    drain(0);
`endif
  endtask

  task automatic test_write_basic();
    wr_phase = 1;
    write_burst(10'h010, 3, 1'b0, 0, 'hA0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[16 + i] !== DW'(16'hA0 + i)) begin
        errors++;
        $display("FAIL wr_basic: mem[%h]=%h required %h",
                 16 + i, mem[16 + i], DW'(16'hA0 + i));
      end
    end
  endtask

  task automatic test_read_latency();
    rd_mode = 0;
    send_cmd(1'b0, 10'h010, 8'd3);
    @(negedge Clk); #1;
    checks++;
    if (RamAddr !== 10'h010 || RdValid !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL rd_lat1: addr=%h rv=%b busy=%b required 010/0/1",
               RamAddr, RdValid, Busy);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk); #1;
      checks++;
      if (RdValid !== 1'b1 || RdData !== DW'(16'hA0 + k) ||
          (k == 3 && Busy !== 1'b0)) begin
        errors++;
        $display("FAIL rd_seq%0d: rv=%b data=%h busy=%b required 1/%h",
                 k, RdValid, RdData, Busy, DW'(16'hA0 + k));
      end
    end
    drain(0);
  endtask

  task automatic test_read_stall();
    rd_mode = 1;
    send_cmd(1'b0, 10'h010, 8'd3);
    drain(1);
  endtask

  task automatic test_wrap();
    int bad;
    write_burst(10'h3FE, 3, 1'b0, 0, 'h5A0);
    checks++;
    if (mem[1022] !== 16'h05A0 || mem[1023] !== 16'h05A1 ||
        mem[0] !== 16'h05A2 || mem[1] !== 16'h05A3) begin
      errors++;
      $display("FAIL wrap: %h %h %h %h required 05a0..05a3",
               mem[1022], mem[1023], mem[0], mem[1]);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wrap_mem: %0d words differ, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    rd_mode = 3;
    WrValid = 1'b1;
    WrData = 16'hDEAD;
    send_cmd(1'b0, 10'h010, 8'd0);
    repeat (3) @(negedge Clk);
    #1;
    checks++;
    if (RdValid !== 1'b1 || RdData !== ref_mem[16] ||
        Busy !== 1'b0 || WrReady !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pend: rv=%b data=%h busy=%b wr=%b required 1/%h/0/0",
               RdValid, RdData, Busy, WrReady, ref_mem[16]);
    end
    send_cmd(1'b0, 10'h011, 8'd2);
    repeat (2) @(negedge Clk);
    #1;
    checks++;
    if (Busy !== 1'b1 || RdValid !== 1'b1 || RdData !== ref_mem[16] ||
        RamAddr !== 10'h011) begin
      errors++;
      $display("FAIL b2b_stall: busy=%b rv=%b data=%h addr=%h required 1/1/%h/011",
               Busy, RdValid, RdData, RamAddr, ref_mem[16]);
    end
    WrValid = 1'b0;
    drain(2);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    int bad;
    for (int n = 0; n < 24; n++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 1) == 1)
        write_burst(a, $urandom_range(0, 20), 1'b1, 0, -1);
      else begin
        rd_mode = $urandom_range(0, 2);
        send_cmd(1'b0, a, LW'($urandom_range(0, 20)));
      end
    end
    drain(2);
    a = AW'($urandom);
    write_burst(a, 255, 1'b0, 0, -1);
    rd_mode = 2;
    send_cmd(1'b0, a, 8'hFF);
    drain(2);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rand_mem: %0d words differ, required 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    write_burst(10'h100, 7, 1'b0, 2, -1);
    Rst_n = 1'b0;
    WrValid = 1'b1;
    WrData = 16'hBEEF;
    #1;
    checks++;
    if (RamAddr !== '0 || RamWrEn !== 1'b0 || RamDataIn !== '0 ||
        RdValid !== 1'b0 || RdData !== '0 || Busy !== RST_BUSY ||
        CmdReady !== !RST_BUSY || WrReady !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: addr=%h we=%b din=%h rv=%b rd=%h busy=%b cr=%b wr=%b",
               RamAddr, RamWrEn, RamDataIn, RdValid, RdData, Busy,
               CmdReady, WrReady);
    end
    exp_q.delete();
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    WrValid = 1'b0;
`ifdef RAM_BURST_CTRL_CLEAR_EN
    wait_clear();
`else
    wr_phase = 0;
`endif
    @(negedge Clk);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_mem: %0d words differ, required 0", bad);
    end
  endtask

  initial begin
    checks = 0; errors = 0; rd_mode = 0; wr_phase = RST_BUSY;
    Rst_n = 1'b0;
    CmdValid = 0; CmdWrite = 0; CmdAddr = '0; CmdLen = '0;
    WrValid = 0; WrData = '0; RdReady = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DW'($urandom);
      ref_mem[i] = mem[i];
    end
    test_reset();
    test_write_basic();
    test_read_latency();
    test_read_stall();
    test_wrap();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
